riskow_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter in front of the Riskow shared data bus (RAM and IO port space).
- Master 0 is the CPU load/store unit; master 1 is a DMA/debug loader.
- Round-robin grant, single outstanding transaction, registered request and response.
- A bus-timeout watchdog terminates a stuck slave access with an error response.

---
 rtl/riskow_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_riskow_bus_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/riskow_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the Riskow data bus.
// Single outstanding transaction with a watchdog that aborts a stuck slave access.
module riskow_bus_arbiter #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                TIMEOUT  = 255,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  m0_valid_i,
   input  logic [ADDR_W-1:0]     m0_addr_i,
   input  logic [DATA_W-1:0]     m0_wdata_i,
   input  logic                  m0_we_i,
   input  logic [DATA_W/8-1:0]   m0_wmask_i,
   input  logic                  m1_valid_i,
   input  logic [ADDR_W-1:0]     m1_addr_i,
   input  logic [DATA_W-1:0]     m1_wdata_i,
   input  logic                  m1_we_i,
   input  logic [DATA_W/8-1:0]   m1_wmask_i,
   output logic                  m0_ready_o,
   output logic                  m1_ready_o,
   output logic [DATA_W-1:0]     m_rdata_o,
   output logic                  m_error_o,
   output logic                  s_valid_o,
   output logic [ADDR_W-1:0]     s_addr_o,
   output logic [DATA_W-1:0]     s_wdata_o,
   output logic                  s_we_o,
   output logic [DATA_W/8-1:0]   s_wmask_o,
   input  logic                  s_ready_i,
   input  logic [DATA_W-1:0]     s_rdata_i,
   output logic [ADDR_W-1:0]     err_addr_o
);

   localparam int MASK_W = DATA_W / 8;
   // One spare bit of headroom when the watchdog is disabled keeps the vector legal.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e              state_q;
   logic                last_grant_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                s_valid_q;
   logic [ADDR_W-1:0]   s_addr_q;
   logic [DATA_W-1:0]   s_wdata_q;
   logic                s_we_q;
   logic [MASK_W-1:0]   s_wmask_q;
   logic                m0_ready_q;
   logic                m1_ready_q;
   logic                m_error_q;
   logic [DATA_W-1:0]   m_rdata_q;
   logic [ADDR_W-1:0]   err_addr_q;

   logic                req_d;
   logic                sel_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   wdata_d;
   logic                we_d;
   logic [MASK_W-1:0]   wmask_d;

   // Ties go to whichever master was not served last.
   always_comb begin
      req_d = m0_valid_i | m1_valid_i;
      sel_d = 1'b0;
      if (m0_valid_i && m1_valid_i) sel_d = ~last_grant_q;
      else if (m1_valid_i)          sel_d = 1'b1;
      addr_d  = sel_d ? m1_addr_i  : m0_addr_i;
      wdata_d = sel_d ? m1_wdata_i : m0_wdata_i;
      we_d    = sel_d ? m1_we_i    : m0_we_i;
      wmask_d = sel_d ? m1_wmask_i : m0_wmask_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         s_valid_q    <= 1'b0;
         s_addr_q     <= '0;
         s_wdata_q    <= '0;
         s_we_q       <= 1'b0;
         s_wmask_q    <= '0;
         m0_ready_q   <= 1'b0;
         m1_ready_q   <= 1'b0;
         m_error_q    <= 1'b0;
         m_rdata_q    <= '0;
         err_addr_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_d) begin
                  s_valid_q    <= 1'b1;
                  s_addr_q     <= addr_d;
                  s_wdata_q    <= wdata_d;
                  s_we_q       <= we_d;
                  s_wmask_q    <= wmask_d;
                  last_grant_q <= sel_d;
                  cnt_q        <= '0;
                  state_q      <= BUSY;
               end
            end
            BUSY: begin
               // last_grant_q names the master owning the transaction in flight.
               if (s_ready_i) begin
                  m_rdata_q  <= s_rdata_i;
                  s_valid_q  <= 1'b0;
                  m0_ready_q <= ~last_grant_q;
                  m1_ready_q <= last_grant_q;
                  m_error_q  <= 1'b0;
                  state_q    <= RESP;
               end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                  m_rdata_q  <= ERR_DATA;
                  err_addr_q <= s_addr_q;
                  s_valid_q  <= 1'b0;
                  m0_ready_q <= ~last_grant_q;
                  m1_ready_q <= last_grant_q;
                  m_error_q  <= 1'b1;
                  state_q    <= RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RESP: begin
               m0_ready_q <= 1'b0;
               m1_ready_q <= 1'b0;
               m_error_q  <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m0_ready_o = m0_ready_q;
   assign m1_ready_o = m1_ready_q;
   assign m_rdata_o  = m_rdata_q;
   assign m_error_o  = m_error_q;
   assign s_valid_o  = s_valid_q;
   assign s_addr_o   = s_addr_q;
   assign s_wdata_o  = s_wdata_q;
   assign s_we_o     = s_we_q;
   assign s_wmask_o  = s_wmask_q;
   assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_riskow_bus_arbiter.sv
// Directed bench for riskow_bus_arbiter: cycle table plus timeout, reset and no-watchdog sequences.
module tb_riskow_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        m0_valid, m1_valid, m0_we, m1_we;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_wmask, m1_wmask;
   logic        s_ready, z_s_ready;
   logic [31:0] s_rdata;

   logic        m0_ready, m1_ready, m_error, s_valid, s_we;
   logic [31:0] m_rdata, s_addr, s_wdata, err_addr;
   logic [3:0]  s_wmask;
   logic        z_m0_ready, z_m1_ready, z_m_error, z_s_valid, z_s_we;
   logic [31:0] z_m_rdata, z_s_addr, z_s_wdata, z_err_addr;
   logic [3:0]  z_s_wmask;

   riskow_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .m0_valid_i(m0_valid), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_we_i(m0_we), .m0_wmask_i(m0_wmask),
      .m1_valid_i(m1_valid), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_we_i(m1_we), .m1_wmask_i(m1_wmask),
      .m0_ready_o(m0_ready), .m1_ready_o(m1_ready), .m_rdata_o(m_rdata), .m_error_o(m_error),
      .s_valid_o(s_valid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_we_o(s_we), .s_wmask_o(s_wmask),
      .s_ready_i(s_ready), .s_rdata_i(s_rdata), .err_addr_o(err_addr));

   riskow_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0), .ERR_DATA(32'hDEADBEEF)) dutz (
      .clk_i(clk), .rst_ni(rst_n),
      .m0_valid_i(m0_valid), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_we_i(m0_we), .m0_wmask_i(m0_wmask),
      .m1_valid_i(m1_valid), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_we_i(m1_we), .m1_wmask_i(m1_wmask),
      .m0_ready_o(z_m0_ready), .m1_ready_o(z_m1_ready), .m_rdata_o(z_m_rdata), .m_error_o(z_m_error),
      .s_valid_o(z_s_valid), .s_addr_o(z_s_addr), .s_wdata_o(z_s_wdata), .s_we_o(z_s_we), .s_wmask_o(z_s_wmask),
      .s_ready_i(z_s_ready), .s_rdata_i(s_rdata), .err_addr_o(z_err_addr));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic rst; logic m0v; logic [31:0] m0a; logic m1v; logic [31:0] m1a;
      logic m1we; logic [31:0] m1wd; logic [3:0] m1wm; logic sr; logic [31:0] srd;
      logic sv; logic [31:0] sa; logic swe; logic [31:0] swd; logic [3:0] swm;
      logic r0; logic r1; logic err; logic [31:0] rd;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic m0v, input logic [31:0] m0a,
                               input logic m1v, input logic [31:0] m1a, input logic m1we,
                               input logic [31:0] m1wd, input logic [3:0] m1wm,
                               input logic sr, input logic [31:0] srd,
                               input logic sv, input logic [31:0] sa, input logic swe,
                               input logic [31:0] swd, input logic [3:0] swm,
                               input logic r0, input logic r1, input logic err, input logic [31:0] rd);
      vec_t v;
      v.rst = rst; v.m0v = m0v; v.m0a = m0a; v.m1v = m1v; v.m1a = m1a; v.m1we = m1we;
      v.m1wd = m1wd; v.m1wm = m1wm; v.sr = sr; v.srd = srd; v.sv = sv; v.sa = sa;
      v.swe = swe; v.swd = swd; v.swm = swm; v.r0 = r0; v.r1 = r1; v.err = err; v.rd = rd;
      return v;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      m0_valid = 0; m1_valid = 0; m0_we = 0; m1_we = 0;
      m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
      m0_wmask = 4'hF; m1_wmask = 4'hF; s_ready = 0; z_s_ready = 0; s_rdata = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t vt[$];

   initial begin
      int cnt;
      bit got;
      int pulses;

      // Single read, round robin from reset, then a latched write.
      vt.push_back(mk(1,1,'h100,0,0,0,0,0, 0,0,          1,'h100,0,0,'hF, 0,0,0,0));
      vt.push_back(mk(0,1,'h100,0,0,0,0,0, 0,0,          1,'h100,0,0,'hF, 0,0,0,0));
      vt.push_back(mk(0,1,'h100,0,0,0,0,0, 1,'h12345678, 0,'h100,0,0,'hF, 1,0,0,'h12345678));
      vt.push_back(mk(0,0,'h100,0,0,0,0,0, 0,0,          0,'h100,0,0,'hF, 0,0,0,'h12345678));
      vt.push_back(mk(0,0,'h100,0,0,0,0,0, 0,0,          0,'h100,0,0,'hF, 0,0,0,'h12345678));
      vt.push_back(mk(1,1,'h10,1,'h20,0,0,'hF, 0,0,          1,'h10,0,0,'hF, 0,0,0,0));
      vt.push_back(mk(0,1,'h10,1,'h20,0,0,'hF, 1,'h11111111, 0,'h10,0,0,'hF, 1,0,0,'h11111111));
      vt.push_back(mk(0,1,'h10,1,'h20,0,0,'hF, 1,'hFFFFFFFF, 0,'h10,0,0,'hF, 0,0,0,'h11111111));
      vt.push_back(mk(0,1,'h10,1,'h20,0,0,'hF, 0,0,          1,'h20,0,0,'hF, 0,0,0,'h11111111));
      vt.push_back(mk(0,1,'h10,1,'h20,0,0,'hF, 1,'h22222222, 0,'h20,0,0,'hF, 0,1,0,'h22222222));
      vt.push_back(mk(0,1,'h10,1,'h20,0,0,'hF, 1,'hFFFFFFFF, 0,'h20,0,0,'hF, 0,0,0,'h22222222));
      vt.push_back(mk(0,1,'h10,1,'h20,0,0,'hF, 0,0,          1,'h10,0,0,'hF, 0,0,0,'h22222222));
      vt.push_back(mk(0,1,'h10,1,'h20,0,0,'hF, 1,'h33333333, 0,'h10,0,0,'hF, 1,0,0,'h33333333));
      vt.push_back(mk(0,1,'h10,1,'h20,0,0,'hF, 0,0,          0,'h10,0,0,'hF, 0,0,0,'h33333333));
      vt.push_back(mk(0,1,'h10,1,'h20,0,0,'hF, 0,0,          1,'h20,0,0,'hF, 0,0,0,'h33333333));
      vt.push_back(mk(0,1,'h10,1,'h20,0,0,'hF, 1,'h44444444, 0,'h20,0,0,'hF, 0,1,0,'h44444444));
      vt.push_back(mk(0,0,'h10,0,'h20,0,0,'hF, 0,0,          0,'h20,0,0,'hF, 0,0,0,'h44444444));
      vt.push_back(mk(0,0,0,1,'h40,1,'hA5A5A5A5,'h3, 0,0,          1,'h40,1,'hA5A5A5A5,'h3, 0,0,0,'h44444444));
      vt.push_back(mk(0,0,0,1,'h44,1,'h5A5A5A5A,'hC, 0,0,          1,'h40,1,'hA5A5A5A5,'h3, 0,0,0,'h44444444));
      vt.push_back(mk(0,0,0,1,'h44,1,'h5A5A5A5A,'hC, 0,0,          1,'h40,1,'hA5A5A5A5,'h3, 0,0,0,'h44444444));
      vt.push_back(mk(0,0,0,1,'h44,1,'h5A5A5A5A,'hC, 1,'h0BADF00D, 0,'h40,1,'hA5A5A5A5,'h3, 0,1,0,'h0BADF00D));
      vt.push_back(mk(0,0,0,0,'h44,0,0,0,            0,0,          0,'h40,1,'hA5A5A5A5,'h3, 0,0,0,'h0BADF00D));

      do_reset();
      chk("reset_state",
          {s_valid, s_addr, s_wdata, s_we, s_wmask, m0_ready, m1_ready, m_error, m_rdata, err_addr},
          192'd0);

      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].rst) do_reset();
         m0_valid = vt[i].m0v; m0_addr = vt[i].m0a;
         m1_valid = vt[i].m1v; m1_addr = vt[i].m1a; m1_we = vt[i].m1we;
         m1_wdata = vt[i].m1wd; m1_wmask = vt[i].m1wm;
         s_ready = vt[i].sr; s_rdata = vt[i].srd;
         @(negedge clk);
         chk($sformatf("vec%0d", i),
             {s_valid, s_addr, s_we, s_wdata, s_wmask, m0_ready, m1_ready, m_error, m_rdata},
             {vt[i].sv, vt[i].sa, vt[i].swe, vt[i].swd, vt[i].swm, vt[i].r0, vt[i].r1, vt[i].err, vt[i].rd});
      end

      // Watchdog abort with TIMEOUT=4, then a clean follow-up transaction.
      do_reset();
      m0_valid = 1; m0_addr = 32'h8000_0000;
      cnt = 0; got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (m0_ready || m1_ready) begin
            got = 1;
            chk("to_resp", {m0_ready, m1_ready, m_error, s_valid, m_rdata, err_addr},
                {1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h8000_0000});
            m0_valid = 0;
         end else if (s_valid) cnt++;
      end
      chk("to_ready_seen", 192'(got), 192'd1);
      chk("to_svalid_cycles", 192'(cnt), 192'd4);
      @(negedge clk);
      m0_valid = 1; m0_addr = 32'h200;
      @(negedge clk);
      chk("after_to_grant", {s_valid, s_addr}, {1'b1, 32'h200});
      s_ready = 1; s_rdata = 32'h600D_F00D;
      @(negedge clk);
      chk("after_to_resp", {m0_ready, m1_ready, m_error, m_rdata, err_addr},
          {1'b1, 1'b0, 1'b0, 32'h600D_F00D, 32'h8000_0000});
      s_ready = 0; m0_valid = 0;
      @(negedge clk);

      // Reset while BUSY (m0 served last, so only the reset value makes m0 win next).
      m0_valid = 1; m0_addr = 32'h300;
      @(negedge clk);
      chk("rb_busy", {s_valid, s_addr}, {1'b1, 32'h300});
      #2 rst_n = 1'b0;
      #1 chk("rb_async_drop", {s_valid, s_addr}, {1'b0, 32'h0});
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (m0_ready || m1_ready) pulses++;
      end
      m1_valid = 1; m1_addr = 32'h400;
      rst_n = 1'b1;
      @(negedge clk);
      if (m0_ready || m1_ready) pulses++;
      chk("rb_no_ready", 192'(pulses), 192'd0);
      chk("rb_m0_first", {s_valid, s_addr}, {1'b1, 32'h300});
      s_ready = 1; s_rdata = 32'h1234_ABCD;
      @(negedge clk);
      chk("rb_resp", {m0_ready, m1_ready, m_error, m_rdata}, {1'b1, 1'b0, 1'b0, 32'h1234_ABCD});
      s_ready = 0; m0_valid = 0; m1_valid = 0;
      @(negedge clk);

      // Watchdog disabled: slave answers after 1000 cycles.
      do_reset();
      m0_valid = 1; m0_addr = 32'h500;
      pulses = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (z_m0_ready || z_m1_ready) pulses++;
      end
      chk("nowd_no_abort", 192'(pulses), 192'd0);
      chk("nowd_busy", {z_s_valid, z_s_addr, z_s_we, z_s_wdata, z_s_wmask},
          {1'b1, 32'h500, 1'b0, 32'h0, 4'hF});
      z_s_ready = 1; s_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      chk("nowd_resp", {z_m0_ready, z_m1_ready, z_m_error, z_m_rdata, z_err_addr},
          {1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0});
      z_s_ready = 0; m0_valid = 0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
